// File: rtl/grf_dump_reader.sv
// grf_dump_reader
// Streams a masked snapshot of the general register file out over a
// valid/ready beat interface. Addresses are presented on a dedicated GRF
// read port one register at a time, lowest selected register first. The
// combinational read data, which already includes the GRF same-cycle write
// bypass, is captured into a single output register stage.

module grf_dump_reader #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_req,
    input  logic [31:0] dump_mask,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        dump_busy,
    output logic        dump_done,
    output logic [5:0]  dump_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;

    // Registers selected for this dump that have not been loaded yet.
    logic [31:0] pending;

    // Priority encode the lowest set bit; an empty vector maps to 0.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    // Effective mask at acceptance: $0 is suppressed when SKIP_ZERO is set.
    function automatic logic [31:0] effective_mask(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        if (SKIP_ZERO) begin
            r[0] = 1'b0;
        end
        return r;
    endfunction

    logic        handshake;
    logic        pending_any;
    logic        load;
    logic [31:0] pending_after_load;

    // The read port always points at the next register to be captured, so
    // a write retiring in that cycle is seen through the GRF bypass.
    assign rd_addr            = lowest_set(pending);
    assign pending_any        = (pending != 32'd0);
    assign handshake          = out_valid && out_ready;
    // The output stage can take a new beat when it is empty or being drained
    // in this very cycle.
    assign load               = (state == SCAN) && pending_any && (!out_valid || out_ready);
    // Clearing the lowest set bit is the same as clearing bit rd_addr.
    assign pending_after_load = pending & (pending - 32'd1);

    // Control FSM, selection bookkeeping and the registered output beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pending    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
            dump_count <= '0;
        end else begin
            dump_done <= 1'b0;

            if (handshake) begin
                dump_count <= dump_count + 6'd1;
            end

            // ---- read port -> output beat register ----
            if (load) begin
                out_data  <= rd_data;
                out_index <= rd_addr;
                out_last  <= (pending_after_load == 32'd0);
                out_valid <= 1'b1;
                pending   <= pending_after_load;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Requests arriving while a dump is in flight are dropped,
                    // because they are only looked at here.
                    if (dump_req) begin
                        pending    <= effective_mask(dump_mask);
                        dump_count <= '0;
                        dump_busy  <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (!pending_any) begin
                        // Empty selection: finish without emitting a beat.
                        state     <= IDLE;
                        dump_busy <= 1'b0;
                        dump_done <= 1'b1;
                    end else if (load && (pending_after_load == 32'd0)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Only the final beat can be in flight here.
                    if (handshake && out_last) begin
                        state     <= IDLE;
                        dump_busy <= 1'b0;
                        dump_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grf_dump_reader.sv
// Testbench for grf_dump_reader: models the GRF (with same-cycle write
// bypass) and predicts each dump as an ordered list of (index, value) beats.

module tb_grf_dump_reader;

    localparam bit SKIP_ZERO = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        dump_req;
    logic [31:0] dump_mask;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        out_last;
    logic        dump_busy;
    logic        dump_done;
    logic [5:0]  dump_count;

    // GRF model plus its write port (a write is visible on the read port in
    // the same cycle it is presented).
    logic [31:0] grf [32];
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    assign rd_data = (we && (waddr == rd_addr)) ? wdata : grf[rd_addr];

    grf_dump_reader #(.SKIP_ZERO(SKIP_ZERO)) dut (
        .clk        (clk),
        .reset      (reset),
        .dump_req   (dump_req),
        .dump_mask  (dump_mask),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_data   (out_data),
        .out_last   (out_last),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_count (dump_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge. A GRF write presented last cycle lands here.
    task automatic step();
        @(posedge clk);
        #1;
        if (we) grf[waddr] = wdata;
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 32; k++) begin
            grf[k] = (mode == 0) ? 32'(k * 32'h11) : $urandom;
        end
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 pattern 1,0,0,1,0,1 then high.
    // req_cyc: cycle of an extra dump_req pulse during the dump (-1: none).
    // byp_cyc: cycle in which $5 is written while it is being read (-1: none).
    // rst_after: assert reset once this many beats have handed off (-1: none).
    task automatic run_dump(input logic [31:0] mask, input int rmode, input int req_cyc,
                            input int byp_cyc, input int rst_after, input string name);
        logic [31:0] eff;
        logic [5:0]  pat;
        beat_t       b;
        int          n;
        int          hs;
        int          cyc;
        bit          done;
        bit          stall;
        logic [4:0]  p_idx;
        logic [31:0] p_data;
        logic        p_last;
        logic [4:0]  p_addr;

        pat = 6'b101001;
        eff = mask;
        if (SKIP_ZERO) eff[0] = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            if (eff[k]) begin
                b.idx  = 5'(k);
                b.data = (byp_cyc >= 0 && k == 5) ? 32'hDEADBEEF : grf[k];
                exp_q.push_back(b);
            end
        end
        n = exp_q.size();

        dump_req  = 1'b1;
        dump_mask = mask;
        step();
        dump_req  = 1'b0;
        dump_mask = $urandom;
        check({name, "_busy_start"}, dump_busy, 1);
        check({name, "_count_start"}, dump_count, 0);
        check({name, "_done_start"}, dump_done, 0);

        hs = 0; done = 0; stall = 0;
        p_idx = '0; p_data = '0; p_last = 1'b0; p_addr = '0;
        cyc = 0;
        while (cyc < 400 && !done) begin
            if (dump_done) begin
                done = 1;
                dump_req = 1'b0;
                we = 1'b0;
                check({name, "_busy_end"}, dump_busy, 0);
                if (rmode == 0) check({name, "_done_cycle"}, cyc, n + 1);
                break;
            end
            if (rst_after >= 0 && hs == rst_after) begin
                reset = 1'b0;
                we = 1'b0;
                dump_req = 1'b0;
                #1;
                check({name, "_rst_valid"}, out_valid, 0);
                check({name, "_rst_busy"}, dump_busy, 0);
                check({name, "_rst_count"}, dump_count, 0);
                check({name, "_rst_index"}, out_index, 0);
                check({name, "_rst_data"}, out_data, 0);
                check({name, "_rst_last"}, out_last, 0);
                check({name, "_rst_rdaddr"}, rd_addr, 0);
                step();
                step();
                reset = 1'b1;
                step();
                check({name, "_rst_no_done"}, dump_done, 0);
                return;
            end
            check({name, "_busy"}, dump_busy, 1);
            if (stall) begin
                check({name, "_hold_valid"}, out_valid, 1);
                check({name, "_hold_index"}, out_index, p_idx);
                check({name, "_hold_data"}, out_data, p_data);
                check({name, "_hold_last"}, out_last, p_last);
                check({name, "_hold_rdaddr"}, rd_addr, p_addr);
            end

            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = (cyc < 6) ? pat[cyc] : 1'b1;
            endcase

            we = 1'b0;
            if (cyc == byp_cyc) begin
                check({name, "_byp_rdaddr"}, rd_addr, 5);
                we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
            end else if (byp_cyc >= 0 && cyc == byp_cyc + 1) begin
                we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
            end

            dump_req = (cyc == req_cyc);
            if (cyc == req_cyc) dump_mask = 32'hFFFFFFFF;

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_beat"}, 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check({name, "_index"}, out_index, b.idx);
                    check({name, "_data"}, out_data, b.data);
                    check({name, "_last"}, out_last, (exp_q.size() == 0));
                    hs++;
                end
            end
            stall  = out_valid && !out_ready;
            p_idx  = out_index;
            p_data = out_data;
            p_last = out_last;
            p_addr = rd_addr;
            step();
            cyc++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        check({name, "_handshakes"}, hs, n);
        check({name, "_count"}, dump_count, n);
        check({name, "_missing"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] m;
        reset     = 1'b0;
        dump_req  = 1'b0;
        dump_mask = '0;
        out_ready = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        fill(0);
        #12;
        check("reset_valid", out_valid, 0);
        check("reset_index", out_index, 0);
        check("reset_data", out_data, 0);
        check("reset_last", out_last, 0);
        check("reset_busy", dump_busy, 0);
        check("reset_done", dump_done, 0);
        check("reset_count", dump_count, 0);
        check("reset_rdaddr", rd_addr, 0);
        reset = 1'b1;
        step();

        fill(0);
        run_dump(32'hFFFFFFFF, 0, -1, -1, -1, "full");
        run_dump(32'h80000005, 0, -1, -1, -1, "sparse");
        run_dump(32'h0000000E, 2, -1, -1, -1, "backpressure");
        run_dump(32'h000000A8, 0, -1, 1, -1, "bypass");
        check("bypass_grf_later_write", grf[5], 32'h12345678);
        fill(0);
        run_dump(32'h00000001, 0, -1, -1, -1, "empty");
        run_dump(32'h000000F0, 1, 2, -1, -1, "ignored_req");
        run_dump(32'hFFFFFFFF, 0, -1, -1, 3, "reset_mid");
        run_dump(32'hFFFFFFFF, 1, -1, -1, -1, "after_reset");

        for (int t = 0; t < 12; t++) begin
            fill(1);
            m = $urandom;
            if (t % 3 == 1) m = m & $urandom & $urandom;
            run_dump(m, (t % 4 == 0) ? 0 : 1, (t % 2 == 0) ? int'($urandom_range(0, 8)) : -1,
                     -1, -1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grf_dump_reader.md
# grf_dump_reader

Debug/trace reader that streams a snapshot of general-register-file contents out of the CPU over a valid/ready interface. It sits beside the GRF on a dedicated read port and issues register addresses, one per cycle. It captures the combinational read data, which already includes the GRF's same-cycle write bypass. Registers are selected by a per-dump mask, and each emitted beat carries the register index and value.

## Interface
- SKIP_ZERO, 1: when 1, bit 0 of the mask is forced to 0 at dump start ($0 is never emitted).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- dump_req  in  1  start request; sampled only in IDLE.
- dump_mask  in  32  register select; latched on the cycle dump_req is accepted.
- rd_addr  out  5  GRF read-port address (combinational from state).
- rd_data  in  32  GRF read-port data for rd_addr, same cycle.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat when out_valid && out_ready at posedge.
- out_index  out  5  register number of current beat.
- out_data  out  32  register value of current beat.
- out_last  out  1  current beat is the final beat of the dump.
- dump_busy  out  1  high from the cycle after acceptance until the final handshake.
- dump_done  out  1  one-cycle pulse after the dump finishes.
- dump_count  out  6  beats handed off in the current or most recent dump.

## Operation
- States: IDLE, SCAN, DRAIN.
- Internal register `pending[31:0]` holds the selected registers not yet loaded.
- IDLE:
  - On dump_req: pending <= dump_mask, with bit 0 cleared if SKIP_ZERO; dump_count <= 0; go to SCAN.
  - dump_req outside IDLE is ignored (no queuing).
- rd_addr = index of the lowest set bit of pending, or 0 when pending == 0.
- Load condition: state == SCAN && pending != 0 && (!out_valid || out_ready).
- On load:
  - out_data <= rd_data; out_index <= rd_addr; out_valid <= 1.
  - out_last <= (pending with that bit cleared) == 0.
  - Clear that bit of pending.
- Handshake without a simultaneous load: out_valid <= 0.
- Every handshake increments dump_count.
- SCAN -> DRAIN when a load empties pending.
- SCAN with pending == 0 on entry (empty mask): go to IDLE, pulse dump_done, emit no beats.
- DRAIN -> IDLE on the handshake of the out_last beat; dump_done pulses the following cycle.
- Data semantics:
  - A value is sampled in the cycle its address is on rd_addr, so writes retiring that same cycle are visible (GRF bypass).
  - Writes after sampling are not reflected. The dump is live, not atomic.
- Beats are emitted in ascending register order. Exactly popcount(effective mask) beats.

## Timing
- Reset values:
  - state IDLE; pending 0; rd_addr 0.
  - out_valid 0, out_data 0, out_index 0, out_last 0.
  - dump_busy 0, dump_done 0, dump_count 0.
- Acceptance: dump_req high at edge E0 -> SCAN after E0; first load at E1; out_valid high after E1.
- Throughput: one beat per cycle while out_ready is held high. With N beats, the final handshake is at E(N+1) and dump_done is high during the cycle after E(N+1).
- Backpressure:
  - While out_valid && !out_ready: out_data, out_index and out_last hold stable, and pending and rd_addr do not advance.
  - No beat is dropped or duplicated.
- out_valid never deasserts without a handshake, except on reset.
- Reset asserted mid-dump: all outputs return to reset values asynchronously. The partial dump is abandoned and no dump_done is emitted.
- dump_done and a new dump_req in the same cycle: the request is accepted, because state is already IDLE.

## Test plan
- Full dump: SKIP_ZERO=1, mask 0xFFFFFFFF, register k holds k*0x11, out_ready=1 -> 31 beats, index 1..31, data k*0x11, out_last only on index 31, dump_count=31, dump_done at E33.
- Sparse mask: mask 0x80000005 -> beats index 2 then 31 (bit 0 skipped), out_last on 31, dump_count=2.
- Backpressure: mask 0x0000000E, out_ready toggles 1,0,0,1,0,1 -> indices 1,2,3 in order, fields stable during stall cycles, exactly 3 handshakes.
- Bypass: write $5 <= 0xDEADBEEF in the same cycle rd_addr=5 -> beat index 5 carries 0xDEADBEEF. A later write of $5 leaves the emitted value unchanged.
- Empty mask and ignored request: mask 0x00000001 with SKIP_ZERO=1 -> no out_valid, dump_done one cycle later. A dump_req pulsed mid-dump -> no restart, count unchanged.
- Reset mid-dump: reset low after the 3rd beat of a full dump -> out_valid=0, dump_busy=0, dump_count=0 immediately. A new dump after release starts again from index 1.
